// File: rtl/tilexy_reqmort_sink.sv
// Receiving end of the tile mesh reqmort interface: buffers whole ejected cache lines
// and serializes each one as BEAT_W-bit beats onto the memory-side write port.
module tilexy_reqmort_sink #(
   parameter int DEPTH  = 4,
   parameter int BEAT_W = 66,
   parameter int BEATS  = 8,
   parameter int AFULL  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_en,
   input  logic [BEAT_W*BEATS-1:0]   in_data,
   input  logic [36:0]               in_addr,
   input  logic [41:0]               in_size,
   input  logic                      in_expun,
   output logic                      in_stall,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [BEAT_W-1:0]         mem_beat,
   output logic                      mem_first,
   output logic                      mem_last,
   output logic [36:0]               mem_addr,
   output logic [41:0]               mem_size,
   output logic                      mem_expun,
   output logic                      ovf_err,
   output logic [15:0]               lines_done
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  AFULL_C  = CNT_W'(AFULL);
   localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BEATS - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

   // line storage; contents are only observed through the head pointer while valid
   logic [BEATS-1:0][BEAT_W-1:0] data_q  [DEPTH];
   logic [36:0]                  addr_q  [DEPTH];
   logic [41:0]                  size_q  [DEPTH];
   logic                         expun_q [DEPTH];

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_q, wr_d;
   logic [PTR_W-1:0]    rd_q, rd_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [BIDX_W-1:0]   beat_idx_q, beat_idx_d;
   logic                ovf_q, ovf_d;
   logic [15:0]         done_q, done_d;
   logic                stall_q, stall_d;

   logic                head_last_s;
   logic                xfer_s;
   logic                pop_s;
   logic                push_s;
   logic [CNT_W-1:0]    free_d_s;

   assign mem_valid  = (state_q == ST_SEND);
   assign in_stall   = stall_q;
   assign ovf_err    = ovf_q;
   assign lines_done = done_q;

   // Head-line decode: beat transfer, pop and push qualification
   always_comb begin
      head_last_s = 1'b0;
      xfer_s      = 1'b0;
      pop_s       = 1'b0;
      push_s      = 1'b0;
      if (mem_valid) begin
         head_last_s = expun_q[rd_q] | (beat_idx_q == LAST_IDX);
         xfer_s      = mem_ready;
         pop_s       = mem_ready & head_last_s;
      end else begin
         head_last_s = 1'b0;
      end
      // a full buffer still accepts a line in the same cycle its head retires
      push_s = in_en & ((count_q != DEPTH_C) | pop_s);
   end

   // Next-state for pointers, occupancy, beat index and status
   always_comb begin
      wr_d       = wr_q;
      rd_d       = rd_q;
      count_d    = count_q;
      beat_idx_d = beat_idx_q;
      done_d     = done_q;
      ovf_d      = ovf_q | (in_en & (count_q == DEPTH_C) & ~pop_s);
      if (push_s) begin
         wr_d = wr_q + PTR_W'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) begin
         rd_d       = rd_q + PTR_W'(1);
         beat_idx_d = '0;
         done_d     = done_q + 16'd1;
      end else if (xfer_s) begin
         beat_idx_d = beat_idx_q + BIDX_W'(1);
      end else begin
         beat_idx_d = beat_idx_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      free_d_s = DEPTH_C - count_d;
      stall_d  = (free_d_s <= AFULL_C);
   end

   // Beat FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (push_s) state_d = ST_SEND;
            else        state_d = ST_IDLE;
         end
         ST_SEND: begin
            if (pop_s && (count_d == '0)) state_d = ST_IDLE;
            else                          state_d = ST_SEND;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         beat_idx_q <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 16'd0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         count_q    <= count_d;
         beat_idx_q <= beat_idx_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         stall_q    <= stall_d;
      end
   end

   // Line buffer write port
   always_ff @(posedge clk) begin
      if (push_s) begin
         data_q[wr_q]  <= in_data;
         addr_q[wr_q]  <= in_addr;
         size_q[wr_q]  <= in_size;
         expun_q[wr_q] <= in_expun;
      end
   end

   // Memory-side beat presentation; everything reads zero while idle
   always_comb begin
      mem_beat  = '0;
      mem_first = 1'b0;
      mem_last  = 1'b0;
      mem_addr  = 37'd0;
      mem_size  = 42'd0;
      mem_expun = 1'b0;
      if (mem_valid) begin
         mem_first = (beat_idx_q == '0);
         mem_last  = head_last_s;
         mem_addr  = addr_q[rd_q];
         mem_size  = size_q[rd_q];
         mem_expun = expun_q[rd_q];
         // expunge lines carry a header only, so their single beat is zero
         if (expun_q[rd_q]) mem_beat = '0;
         else               mem_beat = data_q[rd_q][beat_idx_q];
      end else begin
         mem_beat = '0;
      end
   end

endmodule
